kmeans_centroid_collector: RTL and testbench
============================================

Name: kmeans_centroid_collector

Overview:
- Read-side counterpart of the K-means engine's centroid output.
- After the engine finishes, this block fetches every output centroid coordinate through the engine's word-read port, one read outstanding at a time.
- It assembles the coordinates into a flat buffer laid out like the engine's out_centroids array (N_CENT x N_DIM words).
- The UVM reference scoreboard and the top-level result path consume that buffer.

Parameters:
- N_CENT, 4, number of centroids.
- N_DIM, 14, coordinates per centroid.
- DW, 13, coordinate width in bits.
- AW, 8, read address width.
- BASE_ADDR, 0, engine address of coordinate 0.
- TIMEOUT, 64, maximum cycles waited for rd_valid per read.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst, input, 1, asynchronous, active-high reset.
- collect, input, 1, start pulse; sampled only in IDLE.
- busy, output, 1, high from the cycle after collect is accepted until return to IDLE.
- done, output, 1, one-cycle pulse when all words have been captured.
- err, output, 1, sticky timeout flag; cleared on the next accepted collect.
- rd_en, output, 1, read strobe to the engine; one cycle per word.
- rd_addr, output, AW, read address, BASE_ADDR + idx.
- rd_data, input, DW, read data; valid only while rd_valid is high.
- rd_valid, input, 1, read response; arrives no earlier than the cycle after rd_en.
- out_valid, output, 1, high while the buffer holds a complete, error-free set.
- centroids_flat, output, N_CENT*N_DIM*DW, word idx occupies bits [idx*DW +: DW]; idx = k*N_DIM + d.

Behaviour:
- Reset (async, any state): state=IDLE, idx=0, timeout counter=0, buffer all zeros; busy=0, done=0, err=0, rd_en=0, rd_addr=0, out_valid=0. Reset mid-collection discards partial data.
- States:
  - IDLE: collect=1 → REQ; idx=0, err=0, out_valid=0.
  - REQ: rd_en=1, rd_addr=BASE_ADDR+idx for exactly one cycle → WAIT; timeout counter cleared.
  - WAIT: on rd_valid=1, capture rd_data into word idx.
    - If idx==N_CENT*N_DIM-1 → DONE.
    - Otherwise idx++ → REQ.
  - WAIT with rd_valid=0: counter++. When counter reaches TIMEOUT-1 without a response: err=1, out_valid stays 0 → IDLE.
  - DONE: done=1 and out_valid=1 set for this cycle; → IDLE. out_valid then holds until the next accepted collect or reset.
- busy=1 in REQ, WAIT and DONE.
- rd_addr holds its last value outside REQ and is don't-care there; rd_en=0 outside REQ.
- Ignored inputs:
  - collect outside IDLE, including the DONE cycle.
  - rd_valid in IDLE, REQ or DONE; stray responses must not corrupt the buffer.
- Latency (engine answers the cycle after rd_en), with collect sampled at edge 0:
  - word i: rd_en in cycle 1+2i, captured at end of cycle 2+2i.
  - done in cycle 2*N_CENT*N_DIM+1 (=113 with defaults).
- Data handling: no arithmetic on data; address sum truncates to AW bits.
- Words not yet rewritten keep their old values during collection; out_valid=0 marks the buffer stale.

Test Plan:
- Responder returns rd_data = addr*3 mod 8192 with 1-cycle latency, then collect pulse. Required:
  - 56 reads, addresses 0..55, each rd_en one cycle.
  - done at cycle 113; out_valid=1.
  - Word 55 = 165; bits [727:715] = 165.
- Latency sweep: responder latency randomized 1..10 cycles, BASE_ADDR=16. Required:
  - addresses 16..71.
  - Buffer matches the engine out_centroids array word for word.
  - Exactly one done pulse.
- Timeout: responder withholds rd_valid on word 20. Required:
  - err=1 at cycle TIMEOUT after that rd_en; out_valid=0; busy falls.
  - Next collect clears err and a full run succeeds.
- Reset mid-op: assert rst while in WAIT at word 30. Required:
  - All outputs 0 immediately (asynchronous); buffer zero.
  - Following collect restarts at address BASE_ADDR.
- Spurious inputs: second collect at word 10, plus rd_valid pulses in IDLE and REQ. Required:
  - Run unaffected; captures only in WAIT; total rd_en count = 56.
- Back-to-back: collect asserted on the cycle after the done cycle. Required:
  - Accepted; out_valid drops to 0.
  - Second dataset fully replaces the first.

Source files
------------

// File: rtl/kmeans_centroid_collector.sv
// kmeans_centroid_collector
//
// Fetches every output centroid coordinate from the K-means engine through
// its word-read port (one read outstanding at a time) and assembles them into
// a flat buffer laid out like the engine's out_centroids array.
//
// Ports:
//   clk            - single clock, rising edge
//   rst            - asynchronous active-high reset
//   collect        - start pulse, sampled only while idle
//   busy           - high while a collection is in progress
//   done           - one-cycle pulse when the last word has been captured
//   err            - sticky timeout flag, cleared by the next accepted collect
//   rd_en          - one-cycle read strobe per word
//   rd_addr        - read address, BASE_ADDR + word index (truncated to AW)
//   rd_data        - read data, valid while rd_valid is high
//   rd_valid       - read response from the engine
//   out_valid      - buffer holds a complete, error-free set
//   centroids_flat - word idx = k*N_DIM + d at bits [idx*DW +: DW]
module kmeans_centroid_collector #(
    parameter int N_CENT    = 4,
    parameter int N_DIM     = 14,
    parameter int DW        = 13,
    parameter int AW        = 8,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       collect,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       rd_en,
    output logic [AW-1:0]              rd_addr,
    input  logic [DW-1:0]              rd_data,
    input  logic                       rd_valid,
    output logic                       out_valid,
    output logic [N_CENT*N_DIM*DW-1:0] centroids_flat
);

    localparam int NW = N_CENT * N_DIM;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);
    // The counter is tested before it increments, so the give-up point is one
    // below the value it is about to reach (TIMEOUT-1).
    localparam logic [CW-1:0] CNT_LIM  = CW'(TIMEOUT - 2);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    accept;
    logic                    capture;
    logic                    timeout;
    logic [IW-1:0]           idx;
    logic [CW-1:0]           cnt;
    logic                    err_q;
    logic                    ov_q;
    logic [AW-1:0]           addr_q;
    logic [NW*DW-1:0]        buf_q;

    // Engine address for a word index; the sum wraps to AW bits.
    function automatic logic [AW-1:0] addr_of(input logic [IW-1:0] i);
        logic [31:0] s;
        s = 32'(BASE_ADDR) + 32'(i);
        return s[AW-1:0];
    endfunction

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (collect) begin
                    accept    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: state_nxt = WAIT;
            WAIT: begin
                if (rd_valid) begin
                    capture   = 1'b1;
                    state_nxt = (idx == LAST_IDX) ? DONE : REQ;
                end else if (cnt == CNT_LIM) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Reset clears the buffer too, so a collection aborted by reset leaves
    // no partial data behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
            ov_q   <= 1'b0;
            addr_q <= '0;
            buf_q  <= '0;
        end else begin
            if (accept) begin
                idx    <= '0;
                err_q  <= 1'b0;
                ov_q   <= 1'b0;
                addr_q <= addr_of('0);
            end
            if (state == REQ) cnt <= '0;
            if (state == WAIT && !rd_valid) cnt <= cnt + 1'b1;
            if (capture) begin
                buf_q[int'(idx)*DW +: DW] <= rd_data;
                if (idx == LAST_IDX) begin
                    // Raised here so it is already high in the DONE cycle.
                    ov_q <= 1'b1;
                end else begin
                    idx    <= idx + 1'b1;
                    addr_q <= addr_of(idx + 1'b1);
                end
            end
            if (timeout) err_q <= 1'b1;
        end
    end

    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign rd_en          = (state == REQ);
    assign rd_addr        = addr_q;
    assign err            = err_q;
    assign out_valid      = ov_q;
    assign centroids_flat = buf_q;

endmodule

// File: tb/tb_kmeans_centroid_collector.sv
// Testbench for kmeans_centroid_collector: engine responder models with
// programmable latency, a table of full-run scenarios, and hand-written
// sequences for reset, spurious inputs and back-to-back collection.
module tb_kmeans_centroid_collector;

    localparam int NW     = 56;
    localparam int DW     = 13;
    localparam int AW     = 8;
    localparam int FW     = NW * DW;
    localparam int BASE_A = 0;
    localparam int BASE_B = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          collect_a = 1'b0, busy_a, done_a, err_a, rd_en_a, rd_valid_a, out_valid_a;
    logic [AW-1:0] rd_addr_a;
    logic [DW-1:0] rd_data_a;
    logic [FW-1:0] flat_a;
    logic          collect_b = 1'b0, busy_b, done_b, err_b, rd_en_b, rd_valid_b, out_valid_b;
    logic [AW-1:0] rd_addr_b;
    logic [DW-1:0] rd_data_b;
    logic [FW-1:0] flat_b;

    kmeans_centroid_collector u_dut_a (
        .clk(clk), .rst(rst), .collect(collect_a), .busy(busy_a), .done(done_a),
        .err(err_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a), .out_valid(out_valid_a), .centroids_flat(flat_a)
    );

    kmeans_centroid_collector #(.BASE_ADDR(BASE_B)) u_dut_b (
        .clk(clk), .rst(rst), .collect(collect_b), .busy(busy_b), .done(done_b),
        .err(err_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b), .out_valid(out_valid_b), .centroids_flat(flat_b)
    );

    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [DW-1:0] exp_data(input int mode, input int addr);
        int v;
        v = (mode != 0) ? addr * 5 + 7 : addr * 3;
        return DW'(v % 8192);
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Engine model + monitor for DUT A (evaluated on the falling edge).
    int lat_a = 1, wh_a = -1, mode_a = 0, run_id_a = 0;
    bit spur_idle_a = 1'b0, spur_req_a = 1'b0;
    int seen_a = 0, cyc_a = 0, rden_a = 0, addr_bad_a = 0, done_cnt_a = 0;
    int done_cyc_a = 0, err_cyc_a = 0, pend_a = 0, cnt_a = 0;
    logic [AW-1:0] paddr_a = '0;

    always @(negedge clk) begin
        if (run_id_a != seen_a) begin
            seen_a = run_id_a; cyc_a = 0; rden_a = 0; addr_bad_a = 0;
            done_cnt_a = 0; done_cyc_a = 0; err_cyc_a = 0;
        end
        cyc_a++;
        rd_valid_a = 1'b0;
        rd_data_a  = 13'h1ABC;
        if (rst) begin
            pend_a = 0;
        end else begin
            if (pend_a != 0) begin
                cnt_a--;
                if (cnt_a == 0) begin
                    rd_valid_a = 1'b1;
                    rd_data_a  = exp_data(mode_a, int'(paddr_a));
                    pend_a     = 0;
                end
            end
            if (spur_idle_a || (spur_req_a && rd_en_a)) rd_valid_a = 1'b1;
            if (rd_en_a) begin
                if (int'(rd_addr_a) != (BASE_A + rden_a) % 256) addr_bad_a++;
                if (rden_a != wh_a) begin
                    pend_a = 1; cnt_a = lat_a; paddr_a = rd_addr_a;
                end
                rden_a++;
            end
            if (done_a) begin
                done_cnt_a++;
                if (done_cnt_a == 1) done_cyc_a = cyc_a;
            end
            if (err_a && err_cyc_a == 0) err_cyc_a = cyc_a;
        end
    end

    // Engine model + monitor for DUT B: random 1..10 cycle latency per read.
    int run_id_b = 0, seen_b = 0, rden_b = 0, addr_bad_b = 0, done_cnt_b = 0;
    int pend_b = 0, cnt_b = 0;
    logic [AW-1:0] paddr_b = '0;

    always @(negedge clk) begin
        if (run_id_b != seen_b) begin
            seen_b = run_id_b; rden_b = 0; addr_bad_b = 0; done_cnt_b = 0;
        end
        rd_valid_b = 1'b0;
        rd_data_b  = 13'h0F0F;
        if (rst) begin
            pend_b = 0;
        end else begin
            if (pend_b != 0) begin
                cnt_b--;
                if (cnt_b == 0) begin
                    rd_valid_b = 1'b1;
                    rd_data_b  = exp_data(0, int'(paddr_b));
                    pend_b     = 0;
                end
            end
            if (rd_en_b) begin
                if (int'(rd_addr_b) != (BASE_B + rden_b) % 256) addr_bad_b++;
                pend_b = 1; cnt_b = int'($urandom_range(10, 1)); paddr_b = rd_addr_b;
                rden_b++;
            end
            if (done_b) done_cnt_b++;
        end
    end

    task automatic start_a();
        @(negedge clk);
        #1;
        run_id_a++;
        collect_a = 1'b1;
        @(posedge clk);
        #1 collect_a = 1'b0;
    endtask

    task automatic wait_idle_a(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!busy_a) begin ok = 1'b1; break; end
        end
        #1;
        check({nm, " completes"}, ok, 1);
    endtask

    task automatic check_buf_a(input string nm, input int mode);
        int bad = 0;
        for (int i = 0; i < NW; i++)
            if (flat_a[i*DW +: DW] !== exp_data(mode, BASE_A + i)) bad++;
        check(nm, bad, 0);
    endtask

    typedef struct {
        int lat;   // responder latency
        int wh;    // word index whose response is withheld (-1: none)
        int rden;  // expected rd_en count
        int dcnt;  // expected done pulses
        int dcyc;  // expected done cycle (0: none)
        int ecyc;  // expected first cycle with err high (0: none)
        int ov;    // expected out_valid at end
    } row_t;

    row_t rows[6];

    initial begin
        rows[0] = '{1,  -1, 56, 1, 113,  0,   1};
        rows[1] = '{2,  -1, 56, 1, 169,  0,   1};
        rows[2] = '{63, -1, 56, 1, 3585, 0,   1};
        rows[3] = '{1,  20, 21, 0, 0,    105, 0};
        rows[4] = '{64, -1, 1,  0, 0,    65,  0};
        rows[5] = '{3,  -1, 56, 1, 225,  0,   1};

        rst = 1'b0;
        #1 rst = 1'b1;
        #10;
        check("rst busy", busy_a, 0);
        check("rst done", done_a, 0);
        check("rst err", err_a, 0);
        check("rst rd_en", rd_en_a, 0);
        check("rst rd_addr", rd_addr_a, 0);
        check("rst out_valid", out_valid_a, 0);
        check("rst buffer zero", flat_a == '0, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 6; r++) begin
            lat_a = rows[r].lat;
            wh_a  = rows[r].wh;
            start_a();
            wait_idle_a($sformatf("row%0d", r));
            check($sformatf("row%0d rd_en count", r), rden_a, rows[r].rden);
            check($sformatf("row%0d addr seq errors", r), addr_bad_a, 0);
            check($sformatf("row%0d done pulses", r), done_cnt_a, rows[r].dcnt);
            check($sformatf("row%0d done cycle", r), done_cyc_a, rows[r].dcyc);
            check($sformatf("row%0d err cycle", r), err_cyc_a, rows[r].ecyc);
            check($sformatf("row%0d err", r), err_a, rows[r].ecyc != 0);
            check($sformatf("row%0d out_valid", r), out_valid_a, rows[r].ov);
            if (rows[r].ov != 0) check_buf_a($sformatf("row%0d buffer", r), 0);
            if (r == 0) check("word55 bits", flat_a[727:715], 165);
        end
        wh_a = -1;

        // Stray responses while idle must not touch the finished buffer.
        @(negedge clk);
        #1 spur_idle_a = 1'b1;
        repeat (2) @(negedge clk);
        #1 spur_idle_a = 1'b0;
        repeat (2) @(negedge clk);
        check_buf_a("idle spur buffer", 0);
        check("idle spur out_valid", out_valid_a, 1);

        // Stray responses during REQ plus a second collect at word 10.
        lat_a = 1;
        spur_req_a = 1'b1;
        start_a();
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                #1;
                collect_a = (cyc_a == 21);
                if (!busy_a) begin ok = 1'b1; break; end
            end
            collect_a = 1'b0;
            check("spur completes", ok, 1);
        end
        spur_req_a = 1'b0;
        check("spur rd_en count", rden_a, 56);
        check("spur addr seq errors", addr_bad_a, 0);
        check("spur done pulses", done_cnt_a, 1);
        check("spur done cycle", done_cyc_a, 113);
        check("spur out_valid", out_valid_a, 1);
        check_buf_a("spur buffer", 0);

        // Asynchronous reset while waiting on word 30.
        lat_a = 5;
        start_a();
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                #1;
                if (rden_a == 31 && !rd_en_a && busy_a) begin ok = 1'b1; break; end
            end
            check("reach word 30 wait", ok, 1);
        end
        check("pre-reset buffer nonzero", flat_a != '0, 1);
        rst = 1'b1;
        #1;
        check("midrst busy", busy_a, 0);
        check("midrst done", done_a, 0);
        check("midrst err", err_a, 0);
        check("midrst rd_en", rd_en_a, 0);
        check("midrst rd_addr", rd_addr_a, 0);
        check("midrst out_valid", out_valid_a, 0);
        check("midrst buffer zero", flat_a == '0, 1);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        lat_a = 1;
        start_a();
        wait_idle_a("post-reset");
        check("post-reset rd_en count", rden_a, 56);
        check("post-reset addr seq errors", addr_bad_a, 0);
        check("post-reset done cycle", done_cyc_a, 113);
        check_buf_a("post-reset buffer", 0);

        // Back-to-back: collect on the cycle right after done.
        start_a();
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                if (done_a) begin ok = 1'b1; break; end
            end
            check("b2b first done seen", ok, 1);
        end
        @(negedge clk);
        #1;
        check("b2b out_valid before", out_valid_a, 1);
        run_id_a++;
        mode_a = 1;
        collect_a = 1'b1;
        @(posedge clk);
        #1 collect_a = 1'b0;
        check("b2b accepted busy", busy_a, 1);
        check("b2b out_valid dropped", out_valid_a, 0);
        wait_idle_a("b2b second");
        check("b2b rd_en count", rden_a, 56);
        check("b2b done cycle", done_cyc_a, 113);
        check("b2b out_valid after", out_valid_a, 1);
        check_buf_a("b2b buffer replaced", 1);

        // Randomised latency sweep on the BASE_ADDR=16 instance.
        @(negedge clk);
        #1;
        run_id_b++;
        collect_b = 1'b1;
        @(posedge clk);
        #1 collect_b = 1'b0;
        begin
            bit ok = 1'b0;
            int bad = 0;
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                if (!busy_b) begin ok = 1'b1; break; end
            end
            #1;
            check("sweep completes", ok, 1);
            check("sweep rd_en count", rden_b, 56);
            check("sweep addr seq errors", addr_bad_b, 0);
            check("sweep done pulses", done_cnt_b, 1);
            check("sweep out_valid", out_valid_b, 1);
            check("sweep err", err_b, 0);
            for (int i = 0; i < NW; i++)
                if (flat_b[i*DW +: DW] !== exp_data(0, BASE_B + i)) bad++;
            check("sweep buffer", bad, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
